// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the store buffer and the data-memory datapath.
package store_buffer_pkg;

    localparam int SB_DATA_WIDTH = 32;
    localparam int SB_DEPTH      = 4;

    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_DRAIN = 2'd1,
        PORT_READ  = 2'd2
    } port_mode_e;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store queue: entry array with head/tail/count, exposing every entry
// and its valid bit so the owner can run address matching.
module store_fifo
    import store_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = SB_DATA_WIDTH,
    parameter int DEPTH      = SB_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push_i,
    input  logic [DATA_WIDTH-1:0]                push_addr_i,
    input  logic [DATA_WIDTH-1:0]                push_data_i,
    input  logic                                 pop_i,
    output logic [DATA_WIDTH-1:0]                head_addr_o,
    output logic [DATA_WIDTH-1:0]                head_data_o,
    output logic [$clog2(DEPTH)-1:0]             head_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]     entry_addr_o,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]     entry_data_o,
    output logic [DEPTH-1:0]                     valid_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [PTR_W-1:0]                 head_q, head_d;
    logic [PTR_W-1:0]                 tail_q, tail_d;
    logic [PTR_W:0]                   count_q, count_d;

    // Entry storage is deliberately left out of reset; only the pointers matter.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        head_d = pop_i  ? head_q + 1'b1 : head_q;
        tail_d = push_i ? tail_q + 1'b1 : tail_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // An entry is live when its distance from head is below count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset  = '0;
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset     = PTR_W'(i) - head_q;
            valid_o[i] = ({1'b0, offset} < count_q);
        end
    end

    assign head_addr_o  = addr_q[head_q];
    assign head_data_o  = data_q[head_q];
    assign head_o       = head_q;
    assign full_o       = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign entry_addr_o = addr_q;
    assign entry_data_o = data_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data memory: posts stores, drains one per
// cycle, forwards loads from the youngest matching queued store.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = SB_DATA_WIDTH,
    parameter int DEPTH      = SB_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  StoreValid,
    input  logic [DATA_WIDTH-1:0] StoreAddress,
    input  logic [DATA_WIDTH-1:0] StoreData,
    output logic                  StoreReady,
    input  logic                  LoadValid,
    input  logic [DATA_WIDTH-1:0] LoadAddress,
    output logic [DATA_WIDTH-1:0] LoadData,
    output logic                  LoadStall,
    output logic                  Empty,
    output logic [DATA_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] MemReadData
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                             push_s, pop_s, full_s, empty_s;
    logic [DATA_WIDTH-1:0]            head_addr_s, head_data_s;
    logic [PTR_W-1:0]                 head_s;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] entry_addr_s, entry_data_s;
    logic [DEPTH-1:0]                 valid_s;
    logic                             match_s, load_hit_s, drain_s;
    logic [DATA_WIDTH-1:0]            hit_data_s;
    port_mode_e                       mode_s;

    store_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_s),
        .push_addr_i  (StoreAddress),
        .push_data_i  (StoreData),
        .pop_i        (pop_s),
        .head_addr_o  (head_addr_s),
        .head_data_o  (head_data_s),
        .head_o       (head_s),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .entry_addr_o (entry_addr_s),
        .entry_data_o (entry_data_s),
        .valid_o      (valid_s)
    );

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        match_s    = 1'b0;
        hit_data_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_s + PTR_W'(k);
            if (valid_s[idx] && (entry_addr_s[idx] == LoadAddress)) begin
                match_s    = 1'b1;
                hit_data_s = entry_data_s[idx];
            end else begin
                match_s    = match_s;
                hit_data_s = hit_data_s;
            end
        end
    end

    // A full queue always wins the port so a missing load can never starve it.
    always_comb begin
        load_hit_s = LoadValid & match_s;
        drain_s    = !empty_s & (!LoadValid | load_hit_s | full_s);
        if (drain_s) begin
            mode_s = PORT_DRAIN;
        end else if (LoadValid && !load_hit_s) begin
            mode_s = PORT_READ;
        end else begin
            mode_s = PORT_IDLE;
        end
    end

    always_comb begin
        case (mode_s)
            PORT_DRAIN: begin
                MemWrite     = 1'b1;
                MemRead      = 1'b0;
                MemAddress   = head_addr_s;
                MemWriteData = head_data_s;
            end
            PORT_READ: begin
                MemWrite     = 1'b0;
                MemRead      = 1'b1;
                MemAddress   = LoadAddress;
                MemWriteData = '0;
            end
            default: begin
                MemWrite     = 1'b0;
                MemRead      = 1'b0;
                MemAddress   = '0;
                MemWriteData = '0;
            end
        endcase
    end

    always_comb begin
        if (load_hit_s) begin
            LoadData = hit_data_s;
        end else if (mode_s == PORT_READ) begin
            LoadData = MemReadData;
        end else begin
            LoadData = '0;
        end
    end

    assign push_s     = StoreValid & !full_s;
    assign pop_s      = (mode_s == PORT_DRAIN);
    assign StoreReady = !full_s;
    assign LoadStall  = LoadValid & !load_hit_s & full_s;
    assign Empty      = empty_s;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer with a behavioural data memory attached.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        StoreValid, LoadValid;
    logic [31:0] StoreAddress, StoreData, LoadAddress;
    logic        StoreReady, LoadStall, Empty, MemWrite, MemRead;
    logic [31:0] LoadData, MemAddress, MemWriteData, MemReadData;

    logic        ram_init;
    logic [31:0] ram [0:63];

    logic [31:0] exp_load_q  [$];
    logic [63:0] exp_write_q [$];

    int checks   = 0;
    int failures = 0;

    store_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .StoreValid   (StoreValid),
        .StoreAddress (StoreAddress),
        .StoreData    (StoreData),
        .StoreReady   (StoreReady),
        .LoadValid    (LoadValid),
        .LoadAddress  (LoadAddress),
        .LoadData     (LoadData),
        .LoadStall    (LoadStall),
        .Empty        (Empty),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData)
    );

    always #5 clk = ~clk;

    // Data memory: initial pattern 0x1000+index, write on edge, combinational read.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h1000 + i;
        end else if (MemWrite === 1'b1) begin
            ram[MemAddress[5:0]] <= MemWriteData;
        end
    end
    assign MemReadData = ram[MemAddress[5:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever a load completes or a write is issued.
    always @(negedge clk) begin
        if (LoadValid === 1'b1 && LoadStall === 1'b0) begin
            if (exp_load_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL load_unexpected actual=%h required=none", LoadData);
            end else begin
                chk("load_data", LoadData, exp_load_q.pop_front());
            end
        end
        if (MemWrite === 1'b1) begin
            if (exp_write_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL write_unexpected actual=%h:%h required=none", MemAddress, MemWriteData);
            end else begin
                logic [63:0] w;
                w = exp_write_q.pop_front();
                chk("write_addr", MemAddress, w[63:32]);
                chk("write_data", MemWriteData, w[31:0]);
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        StoreValid = 1'b1; StoreAddress = a; StoreData = d;
        exp_write_q.push_back({a, d});
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] e);
        LoadValid = 1'b1; LoadAddress = a;
        exp_load_q.push_back(e);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ram_init = 1'b1;
        StoreValid = 1'b0; StoreAddress = '0; StoreData = '0;
        LoadValid = 1'b0; LoadAddress = '0;
        step();
        ram_init = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("rst_store_ready", {31'd0, StoreReady}, 32'd1);
        chk("rst_empty",       {31'd0, Empty},      32'd1);
        chk("rst_mem_write",   {31'd0, MemWrite},   32'd0);
        chk("rst_mem_read",    {31'd0, MemRead},    32'd0);
        chk("rst_load_stall",  {31'd0, LoadStall},  32'd0);
        chk("rst_load_data",   LoadData,            32'd0);
        chk("rst_mem_addr",    MemAddress,          32'd0);

        // Simple store, drain next cycle, then read back from memory.
        store(32'd5, 32'hDEADBEEF);
        step();
        StoreValid = 1'b0;
        #1;
        chk("t2_mem_write", {31'd0, MemWrite}, 32'd1);
        chk("t2_mem_addr",  MemAddress,        32'd5);
        step();
        chk("t2_empty", {31'd0, Empty}, 32'd1);
        load(32'd5, 32'hDEADBEEF);
        #1;
        chk("t2_mem_read", {31'd0, MemRead}, 32'd1);
        step();
        LoadValid = 1'b0;

        // Same-cycle store is invisible; next cycle the load forwards while draining.
        store(32'd9, 32'h11);
        load(32'd9, 32'h1009);
        step();
        StoreValid = 1'b0;
        load(32'd9, 32'h11);
        #1;
        chk("t3_drain_parallel", {31'd0, MemWrite}, 32'd1);
        step();
        LoadValid = 1'b0;
        step();

        // Youngest match wins while misses to 7 hold the queue.
        store(32'd3, 32'hA);
        load(32'd7, 32'h1007);
        step();
        store(32'd3, 32'hB);
        load(32'd7, 32'h1007);
        step();
        StoreValid = 1'b0;
        load(32'd3, 32'hB);
        step();
        LoadValid = 1'b0;
        step();
        chk("t4_empty", {31'd0, Empty}, 32'd1);

        // Fill to DEPTH with missing loads to 20; full queue stalls the load one cycle.
        for (int i = 0; i < 4; i++) begin
            store(32'd30 + i, 32'hC0 + i);
            load(32'd20, 32'h1014);
            step();
        end
        StoreValid = 1'b1; StoreAddress = 32'd50; StoreData = 32'hBAD;
        load(32'd20, 32'h1014);
        #1;
        chk("t5_store_ready", {31'd0, StoreReady}, 32'd0);
        chk("t5_stall",       {31'd0, LoadStall},  32'd1);
        chk("t5_drain",       {31'd0, MemWrite},   32'd1);
        step();
        StoreValid = 1'b0;
        #1;
        chk("t5_stall_clear", {31'd0, LoadStall}, 32'd0);
        chk("t5_mem_read",    {31'd0, MemRead},   32'd1);
        step();
        LoadValid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_empty", {31'd0, Empty}, 32'd1);

        // Reset discards three queued stores; the load to 7 keeps them from draining.
        for (int i = 0; i < 3; i++) begin
            StoreValid = 1'b1; StoreAddress = 32'd60 + i; StoreData = 32'hE0 + i;
            load(32'd7, 32'h1007);
            step();
        end
        StoreValid = 1'b0;
        reset = 1'b1;
        load(32'd7, 32'h1007);
        step();
        reset = 1'b0;
        LoadValid = 1'b0;
        #1;
        chk("t6_empty",       {31'd0, Empty},      32'd1);
        chk("t6_store_ready", {31'd0, StoreReady}, 32'd1);
        chk("t6_mem_write",   {31'd0, MemWrite},   32'd0);
        for (int i = 0; i < 3; i++) step();

        chk("ram_5",  ram[5],  32'hDEADBEEF);
        chk("ram_9",  ram[9],  32'h11);
        chk("ram_3",  ram[3],  32'hB);
        for (int i = 0; i < 4; i++) chk("ram_fill", ram[30 + i], 32'hC0 + i);
        chk("ram_50", ram[50], 32'h1032);
        for (int i = 0; i < 3; i++) chk("ram_reset", ram[60 + i], 32'h103C + i);
        chk("load_q_left",  exp_load_q.size(),  32'd0);
        chk("write_q_left", exp_write_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store buffer between the MIPS MEM pipeline stage and the data memory. Stores are posted into a small circular queue and drained one per cycle into the data memory's write port. Loads are serviced from the memory's combinational read port, or forwarded from the youngest matching queued store. The block owns the data memory's Address/WriteData/MemWrite/MemRead inputs and consumes its ReadData.

## Interface
- DATA_WIDTH, 32, data and address width
- DEPTH, 4, queue entries (power of two, ≥2)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- StoreValid  in  1  pipeline presents a store this cycle
- StoreAddress  in  DATA_WIDTH  word index, same indexing as the data memory
- StoreData  in  DATA_WIDTH  store data
- StoreReady  out  1  queue not full; store accepted on edge iff StoreValid & StoreReady
- LoadValid  in  1  pipeline presents a load this cycle
- LoadAddress  in  DATA_WIDTH  word index
- LoadData  out  DATA_WIDTH  load result, valid when LoadValid & !LoadStall
- LoadStall  out  1  load cannot complete this cycle; pipeline holds it
- Empty  out  1  queue empty (used for syscall/fence drain)
- MemAddress  out  DATA_WIDTH  to data memory Address
- MemWriteData  out  DATA_WIDTH  to data memory WriteData
- MemWrite  out  1  to data memory MemWrite
- MemRead  out  1  to data memory MemRead
- MemReadData  in  DATA_WIDTH  from data memory ReadData (combinational)

## Operation
- State: DEPTH entries {addr, data}, head pointer, tail pointer, count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Push: on an accepted store, the entry is written at tail, tail increments and count increments. A store arriving with an empty queue is not bypassed; it always enqueues.
- Forwarding: LoadHit = LoadValid and any valid entry has addr == LoadAddress (full-width compare).
  - With several matches, the youngest (closest to tail) wins.
  - The entry being drained this cycle still counts as valid for matching.
  - A store pushed in the same cycle is not visible to that cycle's load.
- Port arbitration (combinational, per cycle):
  - drain = count>0 & (!LoadValid | LoadHit | count==DEPTH)
  - When drain is asserted: MemWrite=1, MemAddress/MemWriteData from the head entry, MemRead=0. On the edge, head increments and count decrements.
  - When LoadValid & !LoadHit & !drain: MemRead=1, MemAddress=LoadAddress, LoadData=MemReadData.
  - In all other cases: MemRead=0, MemWrite=0, MemAddress=0, MemWriteData=0.
- LoadData = youngest matching entry's data on a hit; otherwise MemReadData when MemRead; otherwise 0.
- LoadStall = LoadValid & !LoadHit & count==DEPTH. This starvation guard means a full queue always drains.
- StoreReady = count<DEPTH. There is no same-cycle push-while-full, even when a drain occurs in that cycle.
- Push and drain in the same cycle: count is unchanged and both pointers advance.
- LoadValid and StoreValid together are legal and handled independently as above.
- Entry contents are not cleared on reset; only pointers and count are reset.

## Timing
- Reset (synchronous): head=0, tail=0, count=0. With inputs idle, this gives StoreReady=1, Empty=1, MemWrite=0, MemRead=0, LoadStall=0, LoadData=0, MemAddress=0.
- A reset asserted mid-operation discards all queued stores; they are never written.
- Store accepted at edge N: it can drive MemWrite at the earliest during cycle N+1, and the RAM is updated at edge N+1.
- Load latency is zero cycles when not stalled; LoadData is combinational from LoadAddress.
- A load stalled by a full queue completes within one cycle: count drops to DEPTH-1 and the next cycle's load gets the port.
- Empty rises in the cycle after the last drain edge.

## Structure
- The shared constants file holds the DATA_WIDTH default, shared with the data memory and the datapath.
- Sub-module store_fifo: circular entry array, head/tail/count, push/pop, full/empty flags.
  - store_fifo also exposes all entries plus a valid vector for the match logic.
- store_buffer holds the youngest-match priority logic, the arbitration and the output muxes.

## Test plan
- Reset, then idle → StoreReady=1, Empty=1, MemWrite=0, MemRead=0.
- Store addr 5 data 0xDEADBEEF with LoadValid=0 → next cycle MemWrite=1, MemAddress=5, MemWriteData=0xDEADBEEF; the following cycle Empty=1 and a load at 5 returns 0xDEADBEEF from memory.
- Load at 9 in the same cycle as a store to 9 with data 0x11 → the load returns the old RAM value. The next cycle, a load at 9 is forwarded as 0x11 and the drain proceeds in parallel.
- Stores to 3 with data 0xA, then 3 with data 0xB, held in the queue by continuous misses to 7 → a load at 3 returns 0xB (youngest wins). RAM[3] ends as 0xB.
- Fill the queue with 4 stores while loads to 20 keep missing → StoreReady=0 and LoadStall=1 for one cycle, a drain occurs, then the load completes with LoadStall=0.
- Enqueue 3 stores, then assert reset for one edge → count=0, Empty=1, and none of the 3 addresses are written in RAM.
